// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared types and control-word layout for the execute stage.
//   - control word field positions (ALU op, mult/div op, immediate select,
//     immediate extension, HI/LO move op, downstream pass-through bits)
//   - ALU / mult-div / HI-LO move encodings
//   - mult/div FSM state type and a small two's-complement helper
package ex_stage_pkg;

    localparam int DATA_W           = 32;
    localparam int CONTROL_REG_SIZE = 16;

    // Control word layout
    localparam int ALU_OP_LSB  = 0;
    localparam int ALU_OP_MSB  = 3;
    localparam int MD_OP_LSB   = 4;
    localparam int MD_OP_MSB   = 6;
    localparam int ALU_SRC_IMM = 7;
    localparam int IMM_ZEXT    = 8;
    localparam int HILO_OP_LSB = 9;
    localparam int HILO_OP_MSB = 10;
    localparam int PASS_LSB    = 11;  // mem/wb controls, carried through untouched

    // ADD/ADDU and SUB/SUBU share an encoding: there is no overflow trap,
    // so the signed and unsigned forms are the same operation.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_SLLV = 4'd11,
        ALU_SRLV = 4'd12,
        ALU_SRAV = 4'd13,
        ALU_LUI  = 4'd14
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4
    } md_op_e;

    // HI vs LO is taken from funct bit 1 of the instruction
    // (MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13).
    typedef enum logic [1:0] {
        HILO_NONE = 2'd0,
        HILO_MF   = 2'd1,
        HILO_MT   = 2'd2
    } hilo_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v,
                                                   input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/ex_stage_mult_div.sv
// mult_div_unit: iterative multiply/divide with the HI/LO registers.
//   clock, reset         : pipeline clock, synchronous active-high reset
//   start, op            : begin a MULT/MULTU/DIV/DIVU (honoured only when idle)
//   a, b                 : rs / rt operands, latched on the start cycle
//   mthi_we, mtlo_we,
//   mt_data              : direct HI/LO write ports (MTHI/MTLO)
//   busy                 : high while an operation is iterating
//   hi, lo               : architectural HI/LO
// Operands are reduced to magnitudes on start; signs are reapplied on the
// final iteration. MD_CYCLES must equal the data width.
module mult_div_unit
    import ex_stage_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    md_state_e      state, state_nxt;
    md_op_e         op_e;
    logic [CNT_W-1:0] count;
    logic           last;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [63:0]    acc, acc_nxt;
    logic [31:0]    opb_r;       // multiplicand or divisor magnitude
    logic           is_div, neg_res, neg_rem, div0;

    logic           is_signed;
    logic [31:0]    a_abs, b_abs;
    logic [32:0]    add_sum;
    logic [33:0]    trial;
    logic [63:0]    prod_fix;
    logic [31:0]    q_fix, r_fix, hi_fin, lo_fin;
    logic           unused_trial_bit;

    assign op_e      = md_op_e'(op);
    assign is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
    assign a_abs     = negate_if(a, is_signed & a[31]);
    assign b_abs     = negate_if(b, is_signed & b[31]);
    assign busy      = (state == MD_BUSY);
    assign last      = busy && (count == CNT_W'(MD_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: if (last)  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // One iteration. Multiply: LSB-first shift-add. Divide: restoring,
    // using a 33-bit shifted remainder so divisors >= 2^31 work.
    always_comb begin
        add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb_r} : 33'd0);
        trial   = {1'b0, acc[63:31]} - {2'b00, opb_r};
        if (is_div)
            acc_nxt = trial[33] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
        else
            acc_nxt = {add_sum, acc[31:1]};
    end
    // When the subtract succeeds the difference is below the divisor, so bit 32 is 0.
    assign unused_trial_bit = trial[32];

    // Sign fix-up on the final result. A zero divisor leaves quotient all-ones
    // and remainder = |dividend|, which the remainder fix turns back into rs.
    assign prod_fix = neg_res ? (~acc_nxt + 64'd1) : acc_nxt;
    assign q_fix    = div0 ? 32'hFFFF_FFFF : negate_if(acc_nxt[31:0], neg_res);
    assign r_fix    = negate_if(acc_nxt[63:32], neg_rem);
    assign hi_fin   = is_div ? r_fix : prod_fix[63:32];
    assign lo_fin   = is_div ? q_fix : prod_fix[31:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            acc     <= '0;
            opb_r   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            if (state == MD_IDLE && start) begin
                count   <= '0;
                acc     <= {32'd0, a_abs};
                opb_r   <= b_abs;
                is_div  <= (op_e == MD_DIV) || (op_e == MD_DIVU);
                neg_res <= is_signed & (a[31] ^ b[31]);
                neg_rem <= is_signed & a[31];
                div0    <= (b == 32'd0);
            end else if (busy) begin
                acc   <= acc_nxt;
                count <= count + 1'b1;
                if (last) begin
                    hi <= hi_fin;
                    lo <= lo_fin;
                end
            end
            // Moves are stalled while busy, so they never race the final write.
            if (mthi_we) hi <= mt_data;
            if (mtlo_we) lo <= mt_data;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ALU, HI/LO access, mult/div stall, EX/MEM regs).
//   clock, reset : pipeline clock, synchronous active-high reset
//   insn         : instruction word (imm [15:0], shamt [10:6], funct bit 1 = LO)
//   rs_data      : rs operand (forwarded)
//   rt_data      : rt operand (forwarded)
//   control      : decode control word (layout in ex_stage_pkg)
//   alu_result   : registered ALU / HI / LO result (mem address)
//   rt_out       : registered rt_data (store data)
//   control_out  : registered control word
//   stall        : combinational; upstream holds while high
//   md_busy      : mult/div unit iterating
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 insn,
    input  logic [31:0]                 rs_data,
    input  logic [31:0]                 rt_data,
    input  logic [CONTROL_REG_SIZE-1:0] control,
    output logic [31:0]                 alu_result,
    output logic [31:0]                 rt_out,
    output logic [CONTROL_REG_SIZE-1:0] control_out,
    output logic                        stall,
    output logic                        md_busy
);

    alu_op_e     alu_op;
    md_op_e      md_op;
    hilo_op_e    hilo_op;
    logic [31:0] opb, imm_ext, alu_out, ex_result, hi, lo;
    logic [4:0]  shamt, vshamt;
    logic        md_start, mthi_we, mtlo_we, hilo_dep;
    logic        unused_insn_bits;

    assign alu_op  = alu_op_e'(control[ALU_OP_MSB:ALU_OP_LSB]);
    assign md_op   = md_op_e'(control[MD_OP_MSB:MD_OP_LSB]);
    assign hilo_op = hilo_op_e'(control[HILO_OP_MSB:HILO_OP_LSB]);

    assign imm_ext = control[IMM_ZEXT] ? {16'd0, insn[15:0]} : {{16{insn[15]}}, insn[15:0]};
    assign opb     = control[ALU_SRC_IMM] ? imm_ext : rt_data;
    assign shamt   = insn[10:6];
    assign vshamt  = rs_data[4:0];
    assign unused_insn_bits = ^insn[31:16];

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = rs_data + opb;
            ALU_SUB:  alu_out = rs_data - opb;
            ALU_AND:  alu_out = rs_data & opb;
            ALU_OR:   alu_out = rs_data | opb;
            ALU_XOR:  alu_out = rs_data ^ opb;
            ALU_NOR:  alu_out = ~(rs_data | opb);
            ALU_SLT:  alu_out = {31'd0, $signed(rs_data) < $signed(opb)};
            ALU_SLTU: alu_out = {31'd0, rs_data < opb};
            ALU_SLL:  alu_out = rt_data << shamt;
            ALU_SRL:  alu_out = rt_data >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(rt_data) >>> shamt);
            ALU_SLLV: alu_out = rt_data << vshamt;
            ALU_SRLV: alu_out = rt_data >> vshamt;
            ALU_SRAV: alu_out = $unsigned($signed(rt_data) >>> vshamt);
            ALU_LUI:  alu_out = {insn[15:0], 16'd0};
            default:  alu_out = '0;
        endcase
    end

    assign ex_result = (hilo_op == HILO_MF) ? (insn[1] ? lo : hi) : alu_out;

    // Anything touching HI/LO waits for the unit; everything else flows past it.
    assign hilo_dep = (md_op != MD_NONE) || (hilo_op != HILO_NONE);
    assign stall    = md_busy && hilo_dep;
    assign md_start = (md_op != MD_NONE) && !md_busy;
    assign mthi_we  = !stall && (hilo_op == HILO_MT) && !insn[1];
    assign mtlo_we  = !stall && (hilo_op == HILO_MT) &&  insn[1];

    mult_div_unit #(.MD_CYCLES(MD_CYCLES)) u_md (
        .clock   (clock),
        .reset   (reset),
        .start   (md_start),
        .op      (control[MD_OP_MSB:MD_OP_LSB]),
        .a       (rs_data),
        .b       (rt_data),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .mt_data (rs_data),
        .busy    (md_busy),
        .hi      (hi),
        .lo      (lo)
    );

    // A stalled instruction leaves a bubble; decode re-presents it next cycle.
    always_ff @(posedge clock) begin
        if (reset || stall) begin
            alu_result  <= '0;
            rt_out      <= '0;
            control_out <= '0;
        end else begin
            alu_result  <= ex_result;
            rt_out      <= rt_data;
            control_out <= control;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed + random check of ex_stage against a behavioural model.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int CW = CONTROL_REG_SIZE;
    localparam logic [31:0] I_MFHI = 32'h0000_0010;
    localparam logic [31:0] I_MTHI = 32'h0000_0011;
    localparam logic [31:0] I_MFLO = 32'h0000_0012;
    localparam logic [31:0] I_MTLO = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   insn, rs_data, rt_data;
    logic [CW-1:0] control;
    logic [31:0]   alu_result, rt_out;
    logic [CW-1:0] control_out;
    logic          stall, md_busy;

    int checks = 0;
    int failures = 0;

    // Model state: architectural HI/LO, pending result and cycles left.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_busy = 0;

    ex_stage #(.MD_CYCLES(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .insn        (insn),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .control     (control),
        .alu_result  (alu_result),
        .rt_out      (rt_out),
        .control_out (control_out),
        .stall       (stall),
        .md_busy     (md_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input alu_op_e op, input md_op_e md, input hilo_op_e ho,
                                         input logic imm, input logic zext, input logic [4:0] pass);
        logic [CW-1:0] c;
        c = '0;
        c[ALU_OP_MSB:ALU_OP_LSB]   = op;
        c[MD_OP_MSB:MD_OP_LSB]     = md;
        c[HILO_OP_MSB:HILO_OP_LSB] = ho;
        c[ALU_SRC_IMM]             = imm;
        c[IMM_ZEXT]                = zext;
        c[CW-1:PASS_LSB]           = pass;
        return c;
    endfunction

    // ISA-level result of an instruction given current architectural HI/LO.
    function automatic logic [31:0] ref_alu(input logic [31:0] i, a, b, input logic [CW-1:0] c);
        logic [31:0] ob;
        logic signed [31:0] sb;
        alu_op_e op;
        op = alu_op_e'(c[ALU_OP_MSB:ALU_OP_LSB]);
        if (hilo_op_e'(c[HILO_OP_MSB:HILO_OP_LSB]) == HILO_MF) return i[1] ? m_lo : m_hi;
        if (c[ALU_SRC_IMM]) ob = c[IMM_ZEXT] ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
        else ob = b;
        sb = b;
        case (op)
            ALU_ADD:  return a + ob;
            ALU_SUB:  return a - ob;
            ALU_AND:  return a & ob;
            ALU_OR:   return a | ob;
            ALU_XOR:  return a ^ ob;
            ALU_NOR:  return ~(a | ob);
            ALU_SLT:  return ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < ob) ? 32'd1 : 32'd0;
            ALU_SLL:  return b << i[10:6];
            ALU_SRL:  return b >> i[10:6];
            ALU_SRA:  return sb >>> i[10:6];
            ALU_SLLV: return b << a[4:0];
            ALU_SRLV: return b >> a[4:0];
            ALU_SRAV: return sb >>> a[4:0];
            ALU_LUI:  return {i[15:0], 16'h0};
            default:  return 32'd0;
        endcase
    endfunction

    task automatic model_md(input md_op_e md, input logic [31:0] a, b);
        longint      sp, q, r;
        logic [63:0] up;
        case (md)
            MD_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p_hi = sp[63:32]; p_lo = sp[31:0];
            end
            MD_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                p_hi = up[63:32]; p_lo = up[31:0];
            end
            MD_DIV: begin
                if (b == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = a; end
                else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    p_lo = q[31:0]; p_hi = r[31:0];
                end
            end
            default: begin
                if (b == 0) begin p_lo = 32'hFFFF_FFFF; p_hi = a; end
                else begin p_lo = a / b; p_hi = a % b; end
            end
        endcase
        m_busy = 32;
    endtask

    // One clock: drive, check stall before the edge, check registers after it.
    task automatic step(input logic [31:0] i, a, b, input logic [CW-1:0] c,
                        input logic rst, output logic stalled);
        md_op_e md;
        hilo_op_e ho;
        logic [31:0] e_res, e_rt;
        logic [CW-1:0] e_ctl;
        md = md_op_e'(c[MD_OP_MSB:MD_OP_LSB]);
        ho = hilo_op_e'(c[HILO_OP_MSB:HILO_OP_LSB]);
        stalled = (m_busy > 0) && ((md != MD_NONE) || (ho != HILO_NONE));
        insn = i; rs_data = a; rt_data = b; control = c; reset = rst;
        @(negedge clock);
        chk("stall", 32'(stall), 32'(stalled));
        e_res = ref_alu(i, a, b, c);
        e_rt = b; e_ctl = c;
        @(posedge clock);
        #1;
        if (rst || stalled) begin e_res = '0; e_rt = '0; e_ctl = '0; end
        if (rst) begin
            m_busy = 0; m_hi = '0; m_lo = '0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_hi = p_hi; m_lo = p_lo; end
        end else begin
            if (ho == HILO_MT) begin if (i[1]) m_lo = a; else m_hi = a; end
            if (md != MD_NONE) model_md(md, a, b);
        end
        chk("alu_result", alu_result, e_res);
        chk("rt_out", rt_out, e_rt);
        chk("control_out", 32'(control_out), 32'(e_ctl));
        chk("md_busy", 32'(md_busy), (m_busy > 0) ? 32'd1 : 32'd0);
    endtask

    // Present an instruction, holding it while the model says stall.
    task automatic issue(input logic [31:0] i, a, b, input logic [CW-1:0] c, output int n_stall);
        logic st;
        n_stall = 0;
        st = 1'b1;
        while (st && n_stall < 40) begin
            step(i, a, b, c, 1'b0, st);
            if (st) n_stall++;
        end
        checks++;
        assert (n_stall < 40) else begin
            failures++;
            $error("FAIL issue_timeout observed=%0d expected=<40", n_stall);
        end
    endtask

    initial begin
        logic st;
        int ns;
        logic [CW-1:0] c_add, c_nop;
        c_add = mk(ALU_ADD, MD_NONE, HILO_NONE, 1'b0, 1'b0, 5'b10101);
        c_nop = '0;

        // Reset state
        step(32'd0, 32'd0, 32'd0, c_nop, 1'b1, st);
        step(32'd0, 32'd0, 32'd0, c_nop, 1'b1, st);

        // ADD 5+7
        issue(32'h0, 32'd5, 32'd7, c_add, ns);
        chk("plan_add_res", alu_result, 32'd12);
        chk("plan_add_rt", rt_out, 32'd7);
        chk("plan_add_stall", 32'(ns), 32'd0);

        // Boundaries: wrap, signed/unsigned compare, arithmetic shift, immediates
        issue(32'h0, 32'hFFFF_FFFF, 32'd1, c_add, ns);
        chk("add_wrap", alu_result, 32'd0);
        issue(32'h0, 32'hFFFF_FFFF, 32'd1, mk(ALU_SLT, MD_NONE, HILO_NONE, 0, 0, 0), ns);
        chk("slt_neg", alu_result, 32'd1);
        issue(32'h0, 32'hFFFF_FFFF, 32'd1, mk(ALU_SLTU, MD_NONE, HILO_NONE, 0, 0, 0), ns);
        chk("sltu_big", alu_result, 32'd0);
        issue(32'h0000_07C0, 32'd0, 32'h8000_0000, mk(ALU_SRA, MD_NONE, HILO_NONE, 0, 0, 0), ns);
        chk("sra_31", alu_result, 32'hFFFF_FFFF);
        issue(32'h0000_FFFF, 32'd1, 32'd0, mk(ALU_ADD, MD_NONE, HILO_NONE, 1, 0, 0), ns);
        chk("addi_sext", alu_result, 32'd0);
        issue(32'h0000_FFFF, 32'd1, 32'd0, mk(ALU_OR, MD_NONE, HILO_NONE, 1, 1, 0), ns);
        chk("ori_zext", alu_result, 32'h0000_FFFF);

        // MULT -3*4 with independent traffic behind it
        issue(32'h0, 32'hFFFF_FFFD, 32'd4, mk(ALU_ADD, MD_MULT, HILO_NONE, 0, 0, 0), ns);
        for (int k = 0; k < 32; k++)
            issue($urandom, $urandom, $urandom, c_add, ns);
        issue(I_MFHI, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("mult_hi", alu_result, 32'hFFFF_FFFF);
        issue(I_MFLO, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("mult_lo", alu_result, 32'hFFFF_FFF4);

        // DIV -7/2 with a dependent MFLO right behind
        issue(32'h0, 32'hFFFF_FFF9, 32'd2, mk(ALU_ADD, MD_DIV, HILO_NONE, 0, 0, 0), ns);
        issue(I_MFLO, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("div_stall_cycles", 32'(ns), 32'd32);
        chk("div_lo", alu_result, 32'hFFFF_FFFD);
        issue(I_MFHI, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("div_hi", alu_result, 32'hFFFF_FFFF);

        // DIVU by zero
        issue(32'h0, 32'h10, 32'd0, mk(ALU_ADD, MD_DIVU, HILO_NONE, 0, 0, 0), ns);
        issue(I_MFLO, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("divu0_lo", alu_result, 32'hFFFF_FFFF);
        issue(I_MFHI, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("divu0_hi", alu_result, 32'h10);

        // MTLO then MFLO, then MULTU max*max
        issue(I_MTLO, 32'h1234, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MT, 0, 0, 0), ns);
        issue(I_MFLO, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("mtlo_mflo", alu_result, 32'h1234);
        chk("mtlo_nostall", 32'(ns), 32'd0);
        issue(32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(ALU_ADD, MD_MULTU, HILO_NONE, 0, 0, 0), ns);
        issue(I_MFHI, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("multu_hi", alu_result, 32'hFFFF_FFFE);
        issue(I_MFLO, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("multu_lo", alu_result, 32'h1);

        // Dependent instruction on the final busy cycle
        issue(32'h0, 32'd7, 32'd9, mk(ALU_ADD, MD_MULTU, HILO_NONE, 0, 0, 0), ns);
        for (int k = 0; k < 31; k++)
            issue($urandom, $urandom, $urandom, c_add, ns);
        issue(I_MFLO, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("final_cycle_stall", 32'(ns), 32'd1);
        chk("final_cycle_lo", alu_result, 32'd63);

        // Reset on busy cycle 10 aborts the MULT
        issue(32'h0, 32'h0001_2345, 32'h777, mk(ALU_ADD, MD_MULT, HILO_NONE, 0, 0, 0), ns);
        for (int k = 0; k < 9; k++)
            issue($urandom, $urandom, $urandom, c_add, ns);
        step(32'h0, 32'd1, 32'd2, c_add, 1'b1, st);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_res", alu_result, 32'd0);
        for (int k = 0; k < 35; k++)
            issue($urandom, $urandom, $urandom, c_add, ns);
        issue(I_MFHI, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("rst_hi", alu_result, 32'd0);
        issue(I_MFLO, 32'd0, 32'd0, mk(ALU_ADD, MD_NONE, HILO_MF, 0, 0, 0), ns);
        chk("rst_lo", alu_result, 32'd0);

        // Random mix
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri, ra, rb;
            logic [CW-1:0] rc;
            int kind;
            kind = $urandom_range(0, 9);
            ri = $urandom;
            ra = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if (kind <= 5)
                rc = mk(alu_op_e'(4'($urandom_range(0, 14))), MD_NONE, HILO_NONE,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom));
            else if (kind <= 7)
                rc = mk(ALU_ADD, md_op_e'(3'($urandom_range(1, 4))), HILO_NONE, 0, 0, 5'($urandom));
            else
                rc = mk(ALU_ADD, MD_NONE, ($urandom_range(0, 1) != 0) ? HILO_MF : HILO_MT,
                        0, 0, 5'($urandom));
            issue(ri, ra, rb, rc, ns);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
